tiny_cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the tiny_cpu datapath (PC, IR, 32-bit register file x0..x31, ALU, memory port).
- Sequences fetch, decode, execute, memory and writeback for an RV32I subset, and drives the datapath strobes and muxes.
- Contains a tick divider so the core can run at a slow, LED-visible rate. Also provides a retired-instruction counter and halt/error status.

---
 rtl/tiny_cpu_sequencer_if.sv | 28 ++
 rtl/tiny_cpu_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_tiny_cpu_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_sequencer_if.sv
// Control/status bundle between the tiny_cpu sequencer and its datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface tiny_cpu_sequencer_if;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        alu_src_imm;

  modport master (
    input  instr, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           rf_we, wb_sel, alu_src_imm
  );

  modport slave (
    output instr, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           rf_we, wb_sel, alu_src_imm
  );
endinterface

// File: rtl/tiny_cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback controller for the tiny_cpu
// RV32I subset, with a step-tick divider, retired-instruction counter and halt status.
module tiny_cpu_sequencer #(
  parameter int TICK_DIV    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 run,
  tiny_cpu_sequencer_if.master bus,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout,
  output logic [15:0]          instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_t           cur_state;
  state_t           nxt_state;
  logic [TCW-1:0]   tick_cnt;
  logic             tick;
  logic [OCW-1:0]   wait_cnt;
  logic             waiting;
  logic             wait_expire;
  logic             retire;
  logic             set_halt;
  logic             set_illegal;
  logic             set_timeout;
  state_t           after_retire;

  // Opcode classification of the current IR.
  logic [6:0] opcode;
  logic [4:0] rd;
  logic       is_op, is_op_imm, is_load, is_store, is_branch, is_jal;
  logic       is_ebreak, is_legal;

  assign opcode    = bus.instr[6:0];
  assign rd        = bus.instr[11:7];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_ebreak = (bus.instr == INSN_EBREAK);
  assign is_legal  = is_op | is_op_imm | is_load | is_store | is_branch | is_jal;

  assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

  // A wait tick is one spent in a memory state without completion; the
  // MEM_TIMEOUT-th such tick is the one that gives up.
  assign waiting     = tick && !bus.mem_ready &&
                       ((cur_state == S_FETCH) || (cur_state == S_MEM));
  assign wait_expire = waiting && (wait_cnt == OCW'(MEM_TIMEOUT - 1));

  assign after_retire = run ? S_FETCH : S_IDLE;
  assign state        = cur_state;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cur_state <= S_IDLE;
      tick_cnt  <= '0;
      wait_cnt  <= '0;
      instret   <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;

      if (nxt_state != cur_state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      instret <= instret + {15'd0, retire};
      halted  <= halted  | set_halt;
      illegal <= illegal | set_illegal;
      timeout <= timeout | set_timeout;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    nxt_state        = cur_state;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.rf_we        = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.alu_src_imm  = 1'b0;
    retire           = 1'b0;
    set_halt         = 1'b0;
    set_illegal      = 1'b0;
    set_timeout      = 1'b0;

    unique case (cur_state)
      S_IDLE: begin
        if (tick && run) nxt_state = S_FETCH;
      end

      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (tick) begin
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            nxt_state = S_DECODE;
          end else if (wait_expire) begin
            nxt_state   = S_HALT;
            set_halt    = 1'b1;
            set_timeout = 1'b1;
          end
        end
      end

      S_DECODE: begin
        if (tick) begin
          if (is_ebreak) begin
            nxt_state = S_HALT;
            set_halt  = 1'b1;
          end else if (is_legal) begin
            nxt_state = S_EXEC;
          end else begin
            nxt_state   = S_HALT;
            set_halt    = 1'b1;
            set_illegal = 1'b1;
          end
        end
      end

      S_EXEC: begin
        bus.alu_src_imm = is_op_imm | is_load | is_store;
        bus.pc_sel      = is_branch & bus.branch_taken;
        if (tick) begin
          if (is_load || is_store) begin
            nxt_state = S_MEM;
          end else if (is_branch) begin
            bus.pc_we = 1'b1;
            retire    = 1'b1;
            nxt_state = after_retire;
          end else begin
            nxt_state = S_WB;
          end
        end
      end

      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = is_store;
        if (tick) begin
          if (bus.mem_ready) begin
            if (is_store) begin
              bus.pc_we = 1'b1;
              retire    = 1'b1;
              nxt_state = after_retire;
            end else begin
              nxt_state = S_WB;
            end
          end else if (wait_expire) begin
            nxt_state   = S_HALT;
            set_halt    = 1'b1;
            set_timeout = 1'b1;
          end
        end
      end

      S_WB: begin
        bus.wb_sel = is_load ? WB_MEM : (is_jal ? WB_PC4 : WB_ALU);
        bus.pc_sel = is_jal;
        if (tick) begin
          bus.rf_we = (rd != 5'd0);
          bus.pc_we = 1'b1;
          retire    = 1'b1;
          nxt_state = after_retire;
        end
      end

      S_HALT: begin
        nxt_state = S_HALT;
      end

      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Directed bench for tiny_cpu_sequencer: three instances cover the default
// configuration, a short memory timeout and a divided step tick.
module tb_tiny_cpu_sequencer;

  localparam logic [31:0] ADDI1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h0030_0113;  // addi x2,x0,3
  localparam logic [31:0] ADD3  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] LW4   = 32'h0000_A203;  // lw   x4,0(x1)
  localparam logic [31:0] SW2   = 32'h0020_A023;  // sw   x2,0(x1)
  localparam logic [31:0] BEQ   = 32'h0020_8063;  // beq  x1,x2,0
  localparam logic [31:0] JAL0  = 32'h0080_006F;  // jal  x0,8
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] BAD   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic CLK, RESETN;
  logic run1, run_t, run4;
  logic [2:0]  st1, stt, st4;
  logic        hlt1, ill1, tmo1, hltt, illt, tmot, hlt4, ill4, tmo4;
  logic [15:0] ret1, rett, ret4;

  tiny_cpu_sequencer_if i1();
  tiny_cpu_sequencer_if it();
  tiny_cpu_sequencer_if i4();

  tiny_cpu_sequencer dut1 (
    .CLK(CLK), .RESETN(RESETN), .run(run1), .bus(i1),
    .state(st1), .halted(hlt1), .illegal(ill1), .timeout(tmo1), .instret(ret1)
  );
  tiny_cpu_sequencer #(.TICK_DIV(1), .MEM_TIMEOUT(4)) dut_t (
    .CLK(CLK), .RESETN(RESETN), .run(run_t), .bus(it),
    .state(stt), .halted(hltt), .illegal(illt), .timeout(tmot), .instret(rett)
  );
  tiny_cpu_sequencer #(.TICK_DIV(4), .MEM_TIMEOUT(15)) dut4 (
    .CLK(CLK), .RESETN(RESETN), .run(run4), .bus(i4),
    .state(st4), .halted(hlt4), .illegal(ill4), .timeout(tmo4), .instret(ret4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus knobs and per-cycle trace for dut1.
  logic [31:0] prog [4];
  int          nprog;
  int          mem_wait;
  logic        bt;
  int          run_until;
  logic [2:0]  st_tr  [16];
  logic [1:0]  wbs_tr [16];
  logic [15:0] ret_tr [16];
  logic        pcw_tr [16], pcs_tr [16], rfw_tr [16], ais_tr [16];
  logic        mrq_tr [16], mwe_tr [16], mas_tr [16];

  task automatic do_reset();
    run1 = 1'b0; run_t = 1'b0; run4 = 1'b0;
    RESETN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  // Emulates IR loading and a memory that answers mem_wait cycles after MEM entry.
  task automatic run1_cycles(input int ncyc);
    int nf = 0;
    int mcnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      run1 = (c < run_until);
      if (st1 == 3'd1) i1.instr = (nf < nprog) ? prog[nf] : NOP;
      i1.mem_ready    = (st1 != 3'd4) || (mcnt >= mem_wait);
      i1.branch_taken = bt;
      #1;
      st_tr[c]  = st1;          wbs_tr[c] = i1.wb_sel;   ret_tr[c] = ret1;
      pcw_tr[c] = i1.pc_we;     pcs_tr[c] = i1.pc_sel;   rfw_tr[c] = i1.rf_we;
      ais_tr[c] = i1.alu_src_imm;
      mrq_tr[c] = i1.mem_req;   mwe_tr[c] = i1.mem_we;   mas_tr[c] = i1.mem_addr_sel;
      if (i1.ir_we) nf++;
      mcnt = (st1 == 3'd4) ? mcnt + 1 : 0;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    #1;
    n_vec++; if (st1 !== 3'd0 || stt !== 3'd0 || st4 !== 3'd0) begin
      n_err++; $display("FAIL reset_state: got %0d/%0d/%0d need 0/0/0", st1, stt, st4); end
    n_vec++; if ({hlt1, ill1, tmo1, hltt, illt, tmot, hlt4, ill4, tmo4} !== 9'd0) begin
      n_err++; $display("FAIL reset_flags: got %b need 0", {hlt1, ill1, tmo1, hltt, illt, tmot, hlt4, ill4, tmo4}); end
    n_vec++; if (ret1 !== 16'd0 || rett !== 16'd0 || ret4 !== 16'd0) begin
      n_err++; $display("FAIL reset_instret: got %0d/%0d/%0d need 0", ret1, rett, ret4); end
    n_vec++; if ({i1.mem_req, i1.ir_we, i1.pc_we, i1.rf_we, i1.mem_we} !== 5'd0) begin
      n_err++; $display("FAIL reset_strobes: got %b need 0", {i1.mem_req, i1.ir_we, i1.pc_we, i1.rf_we, i1.mem_we}); end
  endtask

  task automatic test_program();
    logic [55:0] exp_st = 56'h01235123512351;
    int nrf = 0;
    int nrf_bad = 0;
    prog[0] = ADDI1; prog[1] = ADDI2; prog[2] = ADD3; nprog = 3;
    mem_wait = 0; bt = 1'b0; run_until = 100;
    do_reset();
    run1_cycles(14);
    for (int c = 0; c < 14; c++) begin
      n_vec++; if (st_tr[c] !== exp_st[4*(13-c) +: 3]) begin
        n_err++; $display("FAIL prog_state[%0d]: got %0d need %0d", c, st_tr[c], exp_st[4*(13-c) +: 3]); end
      if (rfw_tr[c]) begin nrf++; if (wbs_tr[c] !== 2'd0) nrf_bad++; end
    end
    n_vec++; if (nrf !== 3 || nrf_bad !== 0) begin
      n_err++; $display("FAIL prog_rf_we: got %0d pulses (%0d bad wb_sel) need 3 (0)", nrf, nrf_bad); end
    n_vec++; if ({ais_tr[3], ais_tr[7], ais_tr[11]} !== 3'b110) begin
      n_err++; $display("FAIL prog_alu_src_imm: got %b need 110", {ais_tr[3], ais_tr[7], ais_tr[11]}); end
    n_vec++; if (ret_tr[13] !== 16'd3) begin
      n_err++; $display("FAIL prog_instret: got %0d need 3", ret_tr[13]); end
  endtask

  task automatic test_load();
    logic [43:0] exp_st = 44'h01234444500;
    int nwb1 = 0;
    int nmwe = 0;
    prog[0] = LW4; nprog = 1;
    mem_wait = 3; bt = 1'b0; run_until = 2;
    do_reset();
    run1_cycles(11);
    for (int c = 0; c < 11; c++) begin
      n_vec++; if (st_tr[c] !== exp_st[4*(10-c) +: 3]) begin
        n_err++; $display("FAIL load_state[%0d]: got %0d need %0d", c, st_tr[c], exp_st[4*(10-c) +: 3]); end
      if (rfw_tr[c] && wbs_tr[c] === 2'd1) nwb1++;
      if (mwe_tr[c]) nmwe++;
    end
    for (int c = 4; c < 8; c++) begin
      n_vec++; if ({mrq_tr[c], mas_tr[c]} !== 2'b11) begin
        n_err++; $display("FAIL load_mem_addr[%0d]: got req/sel %b need 11", c, {mrq_tr[c], mas_tr[c]}); end
    end
    n_vec++; if (nmwe !== 0) begin
      n_err++; $display("FAIL load_mem_we: got %0d cycles need 0", nmwe); end
    n_vec++; if (nwb1 !== 1) begin
      n_err++; $display("FAIL load_rf_we_mem: got %0d need 1", nwb1); end
    n_vec++; if (ret_tr[9] !== 16'd1) begin
      n_err++; $display("FAIL load_instret: got %0d need 1", ret_tr[9]); end
  endtask

  task automatic test_store();
    logic [23:0] exp_st = 24'h012340;
    int nmwe = 0;
    int nrf = 0;
    prog[0] = SW2; nprog = 1;
    mem_wait = 0; bt = 1'b0; run_until = 2;
    do_reset();
    run1_cycles(6);
    for (int c = 0; c < 6; c++) begin
      n_vec++; if (st_tr[c] !== exp_st[4*(5-c) +: 3]) begin
        n_err++; $display("FAIL store_state[%0d]: got %0d need %0d", c, st_tr[c], exp_st[4*(5-c) +: 3]); end
      if (mwe_tr[c]) nmwe++;
      if (rfw_tr[c]) nrf++;
    end
    n_vec++; if (nmwe !== 1 || mwe_tr[4] !== 1'b1) begin
      n_err++; $display("FAIL store_mem_we: got %0d cycles, MEM=%b need 1,1", nmwe, mwe_tr[4]); end
    n_vec++; if (nrf !== 0) begin
      n_err++; $display("FAIL store_rf_we: got %0d need 0", nrf); end
    n_vec++; if ({pcw_tr[4], pcs_tr[4]} !== 2'b10) begin
      n_err++; $display("FAIL store_pc: got we/sel %b need 10", {pcw_tr[4], pcs_tr[4]}); end
    n_vec++; if (ret_tr[5] !== 16'd1) begin
      n_err++; $display("FAIL store_instret: got %0d need 1", ret_tr[5]); end
  endtask

  task automatic test_branch(input logic taken);
    logic [19:0] exp_st = 20'h01230;
    prog[0] = BEQ; nprog = 1;
    mem_wait = 0; bt = taken; run_until = 2;
    do_reset();
    run1_cycles(5);
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (st_tr[c] !== exp_st[4*(4-c) +: 3]) begin
        n_err++; $display("FAIL branch%0d_state[%0d]: got %0d need %0d", taken, c, st_tr[c], exp_st[4*(4-c) +: 3]); end
    end
    n_vec++; if ({pcw_tr[3], pcs_tr[3]} !== {1'b1, taken}) begin
      n_err++; $display("FAIL branch%0d_pc: got we/sel %b need %b", taken, {pcw_tr[3], pcs_tr[3]}, {1'b1, taken}); end
    n_vec++; if (ret_tr[4] !== 16'd1) begin
      n_err++; $display("FAIL branch%0d_instret: got %0d need 1", taken, ret_tr[4]); end
  endtask

  task automatic test_jal_x0();
    logic [23:0] exp_st = 24'h012350;
    int nrf = 0;
    prog[0] = JAL0; nprog = 1;
    mem_wait = 0; bt = 1'b0; run_until = 2;
    do_reset();
    run1_cycles(6);
    for (int c = 0; c < 6; c++) begin
      n_vec++; if (st_tr[c] !== exp_st[4*(5-c) +: 3]) begin
        n_err++; $display("FAIL jal_state[%0d]: got %0d need %0d", c, st_tr[c], exp_st[4*(5-c) +: 3]); end
      if (rfw_tr[c]) nrf++;
    end
    n_vec++; if ({wbs_tr[4], pcw_tr[4], pcs_tr[4]} !== 4'b1011) begin
      n_err++; $display("FAIL jal_wb_pc: got wb/we/sel %b need 1011", {wbs_tr[4], pcw_tr[4], pcs_tr[4]}); end
    n_vec++; if (nrf !== 0) begin
      n_err++; $display("FAIL jal_rd0_rf_we: got %0d need 0", nrf); end
    n_vec++; if (ret_tr[5] !== 16'd1) begin
      n_err++; $display("FAIL jal_instret: got %0d need 1", ret_tr[5]); end
  endtask

  task automatic test_halt(input logic [31:0] insn, input logic exp_ill);
    logic [19:0] exp_st = 20'h01266;
    prog[0] = insn; nprog = 1;
    mem_wait = 0; bt = 1'b0; run_until = 100;
    do_reset();
    run1_cycles(5);
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (st_tr[c] !== exp_st[4*(4-c) +: 3]) begin
        n_err++; $display("FAIL halt%0d_state[%0d]: got %0d need %0d", exp_ill, c, st_tr[c], exp_st[4*(4-c) +: 3]); end
    end
    n_vec++; if ({hlt1, ill1, tmo1} !== {1'b1, exp_ill, 1'b0}) begin
      n_err++; $display("FAIL halt%0d_flags: got h/i/t %b need %b", exp_ill, {hlt1, ill1, tmo1}, {1'b1, exp_ill, 1'b0}); end
    for (int c = 0; c < 4; c++) begin
      run1 = c[0];
      @(negedge CLK); #1;
      n_vec++; if (st1 !== 3'd6 || {i1.mem_req, i1.ir_we, i1.pc_we, i1.rf_we} !== 4'd0) begin
        n_err++; $display("FAIL halt%0d_sticky[%0d]: got state %0d strobes %b need 6,0000", exp_ill, c, st1,
                          {i1.mem_req, i1.ir_we, i1.pc_we, i1.rf_we}); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp_st  = 32'h01111666;
    logic [7:0]  exp_req = 8'b01111000;
    do_reset();
    run_t = 1'b1; it.mem_ready = 1'b0; it.instr = NOP; it.branch_taken = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_vec++; if (stt !== exp_st[4*(7-c) +: 3] || it.mem_req !== exp_req[7-c]) begin
        n_err++; $display("FAIL timeout_seq[%0d]: got state %0d req %b need %0d %b", c, stt, it.mem_req,
                          exp_st[4*(7-c) +: 3], exp_req[7-c]); end
      @(negedge CLK);
    end
    n_vec++; if ({hltt, illt, tmot} !== 3'b101) begin
      n_err++; $display("FAIL timeout_flags: got h/i/t %b need 101", {hltt, illt, tmot}); end
    run_t = 1'b0;
  endtask

  // TICK_DIV=4: state changes only every 4th CLK; strobes last one CLK.
  task automatic test_tick_div4();
    logic [31:0] exp_seq = 32'h01231234;
    logic irw [30];
    logic pcw [30];
    logic mrq [30];
    int nf = 0;
    int nir = 0;
    int npc = 0;
    do_reset();
    run4 = 1'b1; i4.mem_ready = 1'b1; i4.branch_taken = 1'b0; i4.instr = NOP;
    for (int k = 0; k < 30; k++) begin
      if (st4 == 3'd1) i4.instr = (nf == 0) ? BEQ : SW2;
      #1;
      n_vec++; if (st4 !== exp_seq[4*(7-k/4) +: 3]) begin
        n_err++; $display("FAIL div4_state[%0d]: got %0d need %0d", k, st4, exp_seq[4*(7-k/4) +: 3]); end
      irw[k] = i4.ir_we; pcw[k] = i4.pc_we; mrq[k] = i4.mem_req;
      if (i4.ir_we) begin nf++; nir++; end
      if (i4.pc_we) npc++;
      if (k < 29) @(negedge CLK);
    end
    n_vec++; if (nir !== 2 || irw[7] !== 1'b1 || irw[19] !== 1'b1) begin
      n_err++; $display("FAIL div4_ir_we: got %0d pulses (k7=%b k19=%b) need 2 (1,1)", nir, irw[7], irw[19]); end
    n_vec++; if (npc !== 1 || pcw[15] !== 1'b1) begin
      n_err++; $display("FAIL div4_pc_we: got %0d pulses (k15=%b) need 1 (1)", npc, pcw[15]); end
    n_vec++; if ({mrq[3], mrq[4], mrq[5], mrq[6], mrq[7], mrq[28], mrq[29]} !== 7'b0111111) begin
      n_err++; $display("FAIL div4_mem_req_hold: got %b need 0111111",
                        {mrq[3], mrq[4], mrq[5], mrq[6], mrq[7], mrq[28], mrq[29]}); end
    n_vec++; if (i4.mem_we !== 1'b1 || ret4 !== 16'd1) begin
      n_err++; $display("FAIL div4_mid_mem: got mem_we %b instret %0d need 1 1", i4.mem_we, ret4); end
    RESETN = 1'b0;
    #1;
    n_vec++; if (st4 !== 3'd0 || i4.mem_req !== 1'b0 || i4.mem_we !== 1'b0 || ret4 !== 16'd0) begin
      n_err++; $display("FAIL div4_async_reset: got state %0d req %b we %b instret %0d need 0 0 0 0",
                        st4, i4.mem_req, i4.mem_we, ret4); end
    run4 = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  initial begin
    RESETN = 1'b0;
    run1 = 1'b0; run_t = 1'b0; run4 = 1'b0;
    i1.instr = NOP; i1.branch_taken = 1'b0; i1.mem_ready = 1'b1;
    it.instr = NOP; it.branch_taken = 1'b0; it.mem_ready = 1'b1;
    i4.instr = NOP; i4.branch_taken = 1'b0; i4.mem_ready = 1'b1;
    test_reset();
    test_program();
    test_load();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jal_x0();
    test_halt(EBRK, 1'b0);
    test_halt(BAD, 1'b1);
    test_timeout();
    test_tick_div4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish need finish");
    $fatal(1, "watchdog");
  end

endmodule
